// File: rtl/led_trail_pwm.sv
// Per-channel LED fader: a requested channel jumps to full brightness, then decays by DECAY_STEP
// every DECAY_DIV cycles, and each channel drives a registered PWM output. Define LED_TRAIL_GAMMA_EN for squared-brightness compare.
module led_trail_pwm #(
  parameter int CH         = 4,
  parameter int BW         = 8,
  parameter int DECAY_DIV  = 65536,
  parameter int DECAY_STEP = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      pattern,
  output logic [CH-1:0]      pwm_out,
  output logic [CH*BW-1:0]   level,
  output logic               tick
);

  localparam int            DW    = $clog2(DECAY_DIV);
  localparam logic [BW-1:0] LMAX  = '1;
  localparam logic [BW-1:0] STEP  = BW'(DECAY_STEP);
  localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

  logic [CH-1:0] r_pat_q;
  logic [DW-1:0] r_dcnt;
  logic          r_tick;
  logic [BW-1:0] r_pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat_q   <= '0;
      r_dcnt    <= '0;
      r_tick    <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_pat_q   <= pattern;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_dcnt == DLAST) begin
        r_dcnt <= '0;
        r_tick <= 1'b1;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
        r_tick <= 1'b0;
      end
    end
  end

  assign tick = r_tick;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [BW-1:0] r_lvl;
    logic          r_pwm;
    logic [BW-1:0] w_cmp;
    logic          w_full;

`ifdef LED_TRAIL_GAMMA_EN
    logic [2*BW-1:0] w_sq;
    assign w_sq  = {{BW{1'b0}}, r_lvl} * {{BW{1'b0}}, r_lvl};
    assign w_cmp = w_sq[2*BW-1:BW];
`else
    assign w_cmp = r_lvl;
`endif

    // Full-on keys off the raw level so gamma (which maps max to max-1) still has no off-slot.
    assign w_full = (r_lvl == LMAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lvl <= '0;
        r_pwm <= 1'b0;
      end else begin
        if (r_pat_q[gi]) begin
          r_lvl <= LMAX;
        end else if (r_tick) begin
          r_lvl <= (r_lvl > STEP) ? (r_lvl - STEP) : '0;
        end
        r_pwm <= w_full | (r_pwm_cnt < w_cmp);
      end
    end

    assign level[gi*BW +: BW] = r_lvl;
    assign pwm_out[gi]        = r_pwm;
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm (CH=4, BW=4, DECAY_DIV=4, DECAY_STEP=3) with a ticks-since-load reference model.
module tb_led_trail_pwm;

  localparam int CH = 4;
  localparam int BW = 4;
  localparam int DIV = 4;
  localparam int STEP = 3;
  localparam int LMAX = 15;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     pattern;
  logic [CH-1:0]     pwm_out;
  logic [CH*BW-1:0]  level;
  logic              tick;

  led_trail_pwm #(.CH(CH), .BW(BW), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .pattern(pattern),
    .pwm_out(pwm_out), .level(level), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: a channel is either dark or "lit" with n ticks elapsed since its last load.
  int       m_k;
  logic     m_tick;
  logic     m_patq [CH];
  logic     m_lit  [CH];
  int       m_n    [CH];
  logic     m_pwm  [CH];

  function automatic int lvl_of(int i);
    int v;
    if (!m_lit[i]) return 0;
    v = LMAX - STEP * m_n[i];
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int cmp_of(int l);
`ifdef LED_TRAIL_GAMMA_EN
    return (l * l) / 16;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_tick = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_patq[i] = 1'b0; m_lit[i] = 1'b0; m_n[i] = 0; m_pwm[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int cnt;
    int l;
    cnt = m_k % 16;
    for (int i = 0; i < CH; i++) begin
      l = lvl_of(i);
      m_pwm[i] = (l == LMAX) ? 1'b1 : (cnt < cmp_of(l));
    end
    for (int i = 0; i < CH; i++) begin
      if (m_patq[i]) begin
        m_lit[i] = 1'b1; m_n[i] = 0;
      end else if (m_tick && m_lit[i] && m_n[i] < 100) begin
        m_n[i] = m_n[i] + 1;
      end
      m_patq[i] = pattern[i];
    end
    m_k = m_k + 1;
    m_tick = (m_k % DIV) == 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [CH*BW-1:0] el;
    logic [CH-1:0]    ep;
    for (int i = 0; i < CH; i++) begin
      el[i*BW +: BW] = BW'(lvl_of(i));
      ep[i] = m_pwm[i];
    end
    chk("level", level, el);
    chk("pwm_out", pwm_out, ep);
    chk("tick", tick, m_tick);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [CH-1:0]    pat;
    int               n;
    logic [CH*BW-1:0] lvl;
    logic             tk;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Pattern applied for n edges, then level and tick compared; counted from reset release.
    tbl[0] = '{4'b0001, 1, 16'h0000, 1'b0};
    tbl[1] = '{4'b0000, 1, 16'h000F, 1'b0};
    tbl[2] = '{4'b0000, 2, 16'h000F, 1'b1};
    tbl[3] = '{4'b0000, 1, 16'h000C, 1'b0};
    tbl[4] = '{4'b0000, 4, 16'h0009, 1'b0};
    tbl[5] = '{4'b0000, 4, 16'h0006, 1'b0};
    tbl[6] = '{4'b0000, 4, 16'h0003, 1'b0};
    tbl[7] = '{4'b0000, 3, 16'h0003, 1'b1};
    tbl[8] = '{4'b0000, 1, 16'h0000, 1'b0};
    tbl[9] = '{4'b0000, 8, 16'h0000, 1'b0};

    rst = 1'b1;
    pattern = '0;
    model_reset();
    repeat (10) step();
    pattern = 4'b1111;
    repeat (3) step();
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      pattern = tbl[r].pat;
      repeat (tbl[r].n) step();
      chk("tbl_level", level, tbl[r].lvl);
      chk("tbl_tick", tick, tbl[r].tk);
    end

    // Asynchronous reset in the middle of a fade.
    pattern = 4'b1111;
    repeat (2) step();
    pattern = 4'b0000;
    repeat (5) step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_level", level, 16'h0000);
    chk("async_rst_pwm", pwm_out, 4'b0000);
    chk("async_rst_tick", tick, 1'b0);
    repeat (2) step();
    rst = 1'b0;

    // Held request across ticks, released on a tick cycle.
    pattern = 4'b0010;
    repeat (8) step();
    chk("prio_held", level[7:4], 4'd15);
    chk("prio_tick_after_8", tick, 1'b1);
    pattern = 4'b0000;
    step();
    chk("prio_load_wins", level[7:4], 4'd15);
    repeat (3) step();
    chk("prio_hold_until_tick", level[7:4], 4'd15);
    step();
    chk("prio_first_decay", level[7:4], 4'd12);

    // Rotation feed.
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < CH; c++) begin
        pattern = 4'(1 << c);
        repeat (4) step();
      end
    end
    pattern = 4'b0000;
    repeat (24) step();
    chk("rotation_dark", level, 16'h0000);

    // Random sparse requests with occasional reset pulses.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < CH; i++) pattern[i] = ($urandom_range(7) == 0);
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
